hex_mem_arbiter: RTL and testbench
==================================

Name: hex_mem_arbiter

Overview:
- Shares the single host memory write port between NUM_REQ hex event writers, e.g. parallel rasterizer/writer lanes.
- Each writer drives 640-bit beats (10 hexes x 64 bits).
- The block is a round-robin arbiter with burst locking and a one-entry registered output stage.
- It sits between the writers' memory ports and the host memory interface, and gives full throughput of one beat per cycle.

Parameters:
- NUM_REQ, 4, number of requesting writers (2..8).
- MAX_BURST, 4, maximum consecutive beats one requester may hold the grant while it keeps requesting (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at frame begin.
- req_we  in  NUM_REQ  per-requester beat valid.
- req_addr  in  NUM_REQ*32  per-requester address; slice i = [32*i +: 32].
- req_data  in  NUM_REQ*640  per-requester beat; slice i = [640*i +: 640].
- req_ready  out  NUM_REQ  beat of requester i accepted this cycle.
- mem_addr  out  32  host write address.
- mem_data  out  640  host write data.
- mem_we  out  1  host write valid.
- mem_ready  in  1  host accepts the write this cycle.
- grant_id  out  $clog2(NUM_REQ)  requester index of the beat held in the output stage.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_data=0, grant_id=0, req_ready=0, rr pointer=0, burst count=0, owner=none.
- Reset mid-transfer discards the held beat. Requesters must not count a discarded beat as written.
- Transfer definitions:
  - Host side: a transfer occurs when mem_we && mem_ready.
  - Requester side: a transfer occurs when req_we[i] && req_ready[i].
- Output stage is one register slot. load = (!mem_we || mem_ready) && |req_we.
- On load:
  - Capture the winner's addr and data into mem_addr/mem_data.
  - Set mem_we=1 and grant_id=winner.
  - Assert req_ready[winner] in the same cycle (combinational from req_we and the stage state). All other req_ready bits stay 0.
- Latency: exactly 1 cycle from acceptance to mem_we. Back-to-back beats sustain one beat per cycle while mem_ready=1.
- While mem_we && !mem_ready: mem_addr, mem_data, mem_we and grant_id hold stable, and req_ready=0.
- If mem_ready && no req_we, mem_we falls to 0 next cycle. mem_addr and mem_data keep their last values.
- Arbitration:
  - Lock: if the current owner still requests and burst count < MAX_BURST, the owner wins again.
  - Otherwise round-robin: the first requesting index starting from rr pointer, which is (last winner + 1) mod NUM_REQ.
  - Burst count resets to 1 whenever a different requester wins and increments on a repeat win.
  - When the owner drops req_we, the owner is released immediately and round-robin applies that cycle.
- Fairness: any continuously requesting input is served within (NUM_REQ-1)*MAX_BURST+1 loads.
- frame_start:
  - Sets rr pointer=0, clears owner and burst count.
  - Takes effect for the arbitration in the same cycle, so requester 0 has priority on that load.
  - Does not disturb the beat already held in the output stage.
- Simultaneous load and drain in one cycle: the new beat replaces the drained beat and mem_we stays 1.

Optional Feature:
- Macro: HEX_ARB_STATS_EN.
- When defined:
  - Adds output beat_count  NUM_REQ*32 (slice i = beats of requester i transferred to host).
  - Counts on mem_we && mem_ready, attributed to grant_id.
  - Wraps at 2^32.
  - Cleared by reset and by frame_start; a transfer in the frame_start cycle counts as 1 after the clear.
- When undefined: the port and counters are absent, with no other behavioural change.

Decomposition:
- Package hex_gpu_pkg holds:
  - HEX_BEAT_W=640, HEX_ADDR_W=32, HEXES_PER_BEAT=10, HEX_EVENT_W=64.
  - typedef hex_beat_t (logic [HEX_BEAT_W-1:0]).
- Sub-module hex_rr_picker: combinational. Inputs are the request vector, rr pointer, owner, owner-lock flag. Outputs are the one-hot grant and winner index.
- The top holds the output register, burst counter, pointer and the optional stats.

Test Plan:
- Single requester 2 issues 3 beats (addr 0x100, 0x150, 0x1A0) with mem_ready=1 -> req_ready[2] high 3 cycles; mem_we high cycles 1-3 with matching addresses; grant_id=2.
- All 4 requesting continuously, MAX_BURST=4, mem_ready=1 -> grant sequence is 0,0,0,0,1,1,1,1,2,... with no gaps.
- mem_ready held 0 for 5 cycles with beat 0xDEAD in the stage -> mem_addr/mem_data/mem_we stable; req_ready=0 all 5 cycles; beat transfers on the first mem_ready=1.
- Requester 1 owns a burst (count 2) and requester 3 is waiting; frame_start pulses -> next winner is requester 0 if requesting, else 1 (round-robin from 0).
- reset asserted while mem_we=1 and mem_ready=0 -> next cycle mem_we=0, grant_id=0, pointer=0; beat not transferred.
- With HEX_ARB_STATS_EN: 7 beats from requester 0 and 3 from requester 1, then frame_start -> counts read 7 and 3 before the pulse, 0 and 0 after.

Source files
------------

// File: rtl/hex_gpu_pkg.sv
// Shared widths and beat types for the hex event datapath.
package hex_gpu_pkg;

   localparam int unsigned HEX_BEAT_W     = 640;
   localparam int unsigned HEX_ADDR_W     = 32;
   localparam int unsigned HEXES_PER_BEAT = 10;
   localparam int unsigned HEX_EVENT_W    = 64;

   typedef logic [HEX_BEAT_W-1:0] hex_beat_t;
   typedef logic [HEX_ADDR_W-1:0] hex_addr_t;

endpackage

// File: rtl/hex_rr_picker.sv
// Combinational winner selection: locked owner first, otherwise first requester at or after rr_ptr.
module hex_rr_picker #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   input  logic [$clog2(NUM_REQ)-1:0] owner,
   input  logic                       owner_lock,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] winner
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   int unsigned      idx;
   logic [IdxW-1:0]  idx_w;
   logic             found;

   always_comb begin
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      idx_w  = '0;
      if (owner_lock) begin
         grant[owner] = 1'b1;
         winner       = owner;
      end else begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx   = (32'(rr_ptr) + k) % NUM_REQ;
            idx_w = IdxW'(idx);
            if (!found && req[idx_w]) begin
               found        = 1'b1;
               grant[idx_w] = 1'b1;
               winner       = idx_w;
            end
         end
      end
   end

endmodule

// File: rtl/hex_mem_arbiter.sv
// Round-robin, burst-locking arbiter feeding one registered host write slot.
// Optional per-requester transfer counters are built when HEX_ARB_STATS_EN is defined.
module hex_mem_arbiter
   import hex_gpu_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_start,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*HEX_ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*HEX_BEAT_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [HEX_ADDR_W-1:0]          mem_addr,
   output logic [HEX_BEAT_W-1:0]          mem_data,
   output logic                           mem_we,
   input  logic                           mem_ready,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id
`ifdef HEX_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]          beat_count
`endif
);

   localparam int unsigned IdxW   = $clog2(NUM_REQ);
   localparam int unsigned BurstW = 4;
   localparam logic [BurstW-1:0] MaxBurst = BurstW'(MAX_BURST);

   hex_addr_t addr_arr [NUM_REQ];
   hex_beat_t data_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[HEX_ADDR_W*gi +: HEX_ADDR_W];
      assign data_arr[gi] = req_data[HEX_BEAT_W*gi +: HEX_BEAT_W];
   end

   logic              mem_we_q, mem_we_d;
   hex_addr_t         mem_addr_q, mem_addr_d;
   hex_beat_t         mem_data_q, mem_data_d;
   logic [IdxW-1:0]   grant_id_q, grant_id_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   owner_q, owner_d;
   logic              owner_vld_q, owner_vld_d;
   logic [BurstW-1:0] burst_q, burst_d;

   logic [IdxW-1:0]    ptr_eff;
   logic               owner_vld_eff;
   logic               owner_lock;
   logic               load;
   logic [NUM_REQ-1:0] grant;
   logic [IdxW-1:0]    winner;

   // frame_start steers the arbitration of its own cycle, not just the next one.
   assign ptr_eff       = frame_start ? '0 : rr_ptr_q;
   assign owner_vld_eff = owner_vld_q && !frame_start;
   assign owner_lock    = owner_vld_eff && req_we[owner_q] && (burst_q < MaxBurst);
   assign load          = !reset && (!mem_we_q || mem_ready) && (|req_we);

   hex_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req        (req_we),
      .rr_ptr     (ptr_eff),
      .owner      (owner_q),
      .owner_lock (owner_lock),
      .grant      (grant),
      .winner     (winner)
   );

   assign req_ready = load ? grant : '0;

   always_comb begin
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = ptr_eff;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_eff;
      burst_d     = frame_start ? '0 : burst_q;
      if (load) begin
         mem_we_d    = 1'b1;
         mem_addr_d  = addr_arr[winner];
         mem_data_d  = data_arr[winner];
         grant_id_d  = winner;
         rr_ptr_d    = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         owner_d     = winner;
         owner_vld_d = 1'b1;
         burst_d     = owner_lock ? burst_q + 4'd1 : 4'd1;
      end else begin
         if (mem_ready) mem_we_d = 1'b0;
         // An owner that stops requesting loses its lock even while the stage stalls.
         if (!req_we[owner_q]) owner_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
         burst_q     <= '0;
      end else begin
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         grant_id_q  <= grant_id_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
         burst_q     <= burst_d;
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign grant_id = grant_id_q;

`ifdef HEX_ARB_STATS_EN
   logic xfer;
   assign xfer = mem_we_q && mem_ready;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [31:0] cnt_q;
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= '0;
         end else if (xfer && (grant_id_q == IdxW'(gi))) begin
            cnt_q <= (frame_start ? 32'd0 : cnt_q) + 32'd1;
         end else if (frame_start) begin
            cnt_q <= '0;
         end
      end
      assign beat_count[32*gi +: 32] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_hex_mem_arbiter.sv
// Directed and randomized checks of hex_mem_arbiter against a behavioural reference model.
module tb_hex_mem_arbiter;
   import hex_gpu_pkg::*;

   localparam int N  = 4;
   localparam int MB = 4;

   logic              clk = 1'b0;
   logic              reset, frame_start, mem_ready;
   logic [N-1:0]      req_we, req_ready;
   logic [N*32-1:0]   req_addr;
   logic [N*640-1:0]  req_data;
   logic [31:0]       mem_addr;
   logic [639:0]      mem_data;
   logic              mem_we;
   logic [1:0]        grant_id;
`ifdef HEX_ARB_STATS_EN
   logic [N*32-1:0]   beat_count;
`endif

   hex_mem_arbiter #(
      .NUM_REQ   (N),
      .MAX_BURST (MB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_we      (mem_we),
      .mem_ready   (mem_ready),
      .grant_id    (grant_id)
`ifdef HEX_ARB_STATS_EN
      ,
      .beat_count  (beat_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit           m_we;
   logic [31:0]  m_addr;
   logic [639:0] m_data;
   int           m_gid, m_ptr, m_owner, m_burst;
   int unsigned  m_cnt [N];
   bit           m_lock, m_load;
   int           m_win;
   logic [31:0]  m_naddr;
   logic [639:0] m_ndata;
   logic [N-1:0] rdy_seen;
   int           waits [N];

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [639:0] rand_beat();
      logic [639:0] b;
      for (int j = 0; j < 20; j++) b[32*j +: 32] = $urandom;
      return b;
   endfunction

   task automatic set_req(input int i, input bit we, input logic [31:0] a, input logic [639:0] d);
      req_we[i]            = we;
      req_addr[32*i +: 32] = a;
      req_data[640*i +: 640] = d;
   endtask

   task automatic model_reset();
      m_we = 0; m_addr = '0; m_data = '0; m_gid = 0;
      m_ptr = 0; m_owner = -1; m_burst = 0;
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; waits[i] = 0; end
   endtask

   // Winner for this cycle from the arbitration rules.
   task automatic model_comb();
      int ptr, own;
      ptr    = frame_start ? 0 : m_ptr;
      own    = frame_start ? -1 : m_owner;
      m_lock = (own >= 0) && req_we[own] && (m_burst < MB);
      m_win  = -1;
      if (m_lock) m_win = own;
      else
         for (int k = 0; k < N; k++)
            if (m_win < 0 && req_we[(ptr + k) % N]) m_win = (ptr + k) % N;
      m_load = !reset && (!m_we || mem_ready) && (req_we != '0);
      if (m_load) begin
         m_naddr = req_addr[32*m_win +: 32];
         m_ndata = req_data[640*m_win +: 640];
      end
   endtask

   task automatic model_seq();
      if (reset) begin
         model_reset();
      end else begin
         if (frame_start) for (int i = 0; i < N; i++) m_cnt[i] = 0;
         if (m_we && mem_ready) m_cnt[m_gid]++;
         if (frame_start) begin m_ptr = 0; m_owner = -1; m_burst = 0; end
         if (m_load) begin
            m_burst = m_lock ? m_burst + 1 : 1;
            m_owner = m_win;
            m_ptr   = (m_win + 1) % N;
            m_we    = 1; m_addr = m_naddr; m_data = m_ndata; m_gid = m_win;
         end else begin
            if (mem_ready) m_we = 0;
            if (m_owner >= 0 && !req_we[m_owner]) m_owner = -1;
         end
      end
   endtask

   // One clock: check combinational ready mid-cycle, then registered outputs after the edge.
   task automatic cyc();
      logic [N-1:0] exp_rdy;
      int wmax;
      #2;
      model_comb();
      exp_rdy = '0;
      if (m_load) exp_rdy[m_win] = 1'b1;
      rdy_seen = req_ready;
      chk("req_ready", req_ready, exp_rdy);
      @(posedge clk);
      #1;
      // Fairness measured on observed grants: loads a continuous requester waits through.
      wmax = 0;
      for (int i = 0; i < N; i++) begin
         if (reset || frame_start || !req_we[i]) waits[i] = 0;
         else if (rdy_seen != '0) waits[i] = rdy_seen[i] ? 0 : waits[i] + 1;
         if (waits[i] > wmax) wmax = waits[i];
      end
      model_seq();
      chk("fairness", (wmax <= (N - 1) * MB), 1'b1);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data", mem_data, m_data);
      chk("grant_id", grant_id, m_gid);
`ifdef HEX_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("beat_count", beat_count[32*i +: 32], m_cnt[i]);
`endif
   endtask

   logic [31:0]  t1_addr [3] = '{32'h100, 32'h150, 32'h1A0};
   logic [639:0] held;

   initial begin
      reset = 1; frame_start = 0; mem_ready = 0;
      req_we = '0; req_addr = '0; req_data = '0;
      model_reset();
      cyc();
      cyc();
      reset = 0;
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_data", mem_data, 640'h0);
      chk("rst_gid", grant_id, 2'd0);

      // Single requester 2, three beats
      mem_ready = 1;
      for (int b = 0; b < 3; b++) begin
         set_req(2, 1, t1_addr[b], rand_beat());
         cyc();
         chk("t1_ready", rdy_seen, 4'b0100);
         chk("t1_addr", mem_addr, t1_addr[b]);
         chk("t1_gid", grant_id, 2'd2);
         chk("t1_we", mem_we, 1'b1);
      end
      set_req(2, 0, 32'h0, '0);
      cyc();
      chk("t1_idle_we", mem_we, 1'b0);
      chk("t1_idle_addr", mem_addr, 32'h1A0);

      // All four requesting: bursts of MB per requester
      frame_start = 1;
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < N; i++) set_req(i, 1, 32'h1000 * (i + 1) + k, rand_beat());
         cyc();
         frame_start = 0;
         chk("t2_seq", grant_id, (k / MB) % N);
         chk("t2_we", mem_we, 1'b1);
      end

      // Stall with 0xDEAD held
      req_we = '0;
      set_req(0, 1, 32'hDEAD, rand_beat());
      cyc();
      chk("t3_load", mem_addr, 32'hDEAD);
      held = mem_data;
      mem_ready = 0;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++) set_req(i, 1, 32'h2000 + i, rand_beat());
         set_req(0, 1, 32'hBEEF, rand_beat());
         cyc();
         chk("t3_ready", rdy_seen, 4'b0000);
         chk("t3_addr", mem_addr, 32'hDEAD);
         chk("t3_data", mem_data, held);
         chk("t3_we", mem_we, 1'b1);
      end
      mem_ready = 1;
      cyc();
      chk("t3_drain", mem_addr, 32'hBEEF);

      // frame_start while requester 1 owns a burst
      req_we = '0;
      cyc();
      frame_start = 1;
      set_req(1, 1, 32'h3100, rand_beat());
      set_req(3, 1, 32'h3300, rand_beat());
      cyc();
      frame_start = 0;
      chk("t4_first", grant_id, 2'd1);
      cyc();
      chk("t4_burst2", grant_id, 2'd1);
      frame_start = 1;
      cyc();
      frame_start = 0;
      chk("t4_fs_no0", grant_id, 2'd1);
      cyc();
      chk("t4_burst2b", grant_id, 2'd1);
      frame_start = 1;
      set_req(0, 1, 32'h3000, rand_beat());
      cyc();
      frame_start = 0;
      chk("t4_fs_req0", grant_id, 2'd0);

      // Reset while stalled
      mem_ready = 0;
      reset = 1;
      cyc();
      reset = 0;
      chk("t5_ready", rdy_seen, 4'b0000);
      chk("t5_we", mem_we, 1'b0);
      chk("t5_gid", grant_id, 2'd0);
      req_we = '1;
      mem_ready = 1;
      cyc();
      chk("t5_ptr0", grant_id, 2'd0);

`ifdef HEX_ARB_STATS_EN
      req_we = '0;
      cyc();
      frame_start = 1;
      cyc();
      frame_start = 0;
      for (int k = 0; k < 7; k++) begin set_req(0, 1, 32'h4000 + k, rand_beat()); cyc(); end
      req_we = '0;
      for (int k = 0; k < 3; k++) begin set_req(1, 1, 32'h5000 + k, rand_beat()); cyc(); end
      req_we = '0;
      cyc();
      chk("st_cnt0", beat_count[31:0], 32'd7);
      chk("st_cnt1", beat_count[63:32], 32'd3);
      frame_start = 1;
      cyc();
      frame_start = 0;
      chk("st_clr0", beat_count[31:0], 32'd0);
      chk("st_clr1", beat_count[63:32], 32'd0);
`endif

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         reset       = ($urandom_range(99) == 0);
         frame_start = ($urandom_range(29) == 0);
         mem_ready   = ($urandom_range(9) < 7);
         for (int i = 0; i < N; i++)
            set_req(i, ($urandom_range(9) < 6), $urandom, rand_beat());
         cyc();
      end
      reset = 0; frame_start = 0; req_we = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
